battleship_shot_engine: RTL and testbench

- Sequential successor to the combinational shot checker. Holds a loadable ship map of parametrised size and scores one shot at a time, small or big bomb.
- Scans the bomb footprint and its orthogonal ring one cell per clock. Tracks struck cells, the cumulative hit count and the big bombs remaining.
- Sits between the board switch/key inputs and the LED/seven-segment display logic.

---
 rtl/battleship_shot_engine_if.sv | 43 ++++
 rtl/battleship_shot_engine.sv | 186 ++++++++++++++++++
 tb/tb_battleship_shot_engine.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/battleship_shot_engine_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | battleship_shot_engine_if : map-load, shot-request and result bundle       |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
interface battleship_shot_engine_if #(
    parameter int COORD_W   = 4,
    parameter int NUM_SHIPS = 5,
    parameter int SHIP_W    = 3,
    parameter int BL_W      = 2,
    parameter int HIT_W     = 5
) ();
    logic                 map_we;
    logic [COORD_W-1:0]   map_x;
    logic [COORD_W-1:0]   map_y;
    logic [SHIP_W-1:0]    map_ship;
    logic                 score;
    logic [COORD_W-1:0]   shot_x;
    logic [COORD_W-1:0]   shot_y;
    logic                 big;
    logic                 busy;
    logic                 done;
    logic                 is_hit;
    logic                 is_near_miss;
    logic                 is_miss;
    logic [NUM_SHIPS-1:0] biggest_ship;
    logic [HIT_W-1:0]     num_hits;
    logic [BL_W-1:0]      big_left;
    logic                 wrong;

    modport master (
        output map_we, map_x, map_y, map_ship, score, shot_x, shot_y, big,
        input  busy, done, is_hit, is_near_miss, is_miss, biggest_ship,
               num_hits, big_left, wrong
    );

    modport slave (
        input  map_we, map_x, map_y, map_ship, score, shot_x, shot_y, big,
        output busy, done, is_hit, is_near_miss, is_miss, biggest_ship,
               num_hits, big_left, wrong
    );
endinterface
`default_nettype wire

// File: rtl/battleship_shot_engine.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | battleship_shot_engine : ship map plus one-cell-per-clock shot scorer      |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module battleship_shot_engine #(
    parameter int GRID      = 10,
    parameter int COORD_W   = 4,
    parameter int NUM_SHIPS = 5,
    parameter int SHIP_W    = 3,
    parameter int BIG_BOMBS = 3,
    parameter int BL_W      = 2,
    parameter int HIT_W     = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    battleship_shot_engine_if.slave   bus
);
    localparam int c_CELLS = GRID * GRID;
    localparam int c_IDX_W = $clog2(c_CELLS);
    localparam logic [COORD_W-1:0]        c_LO_U = COORD_W'(1);
    localparam logic [COORD_W-1:0]        c_HI_U = COORD_W'(GRID);
    localparam logic signed [COORD_W+1:0] c_LO_S = (COORD_W+2)'(1);
    localparam logic signed [COORD_W+1:0] c_HI_S = (COORD_W+2)'(GRID);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_CHECK  = 2'd1;
    localparam logic [1:0] c_ST_SCAN   = 2'd2;
    localparam logic [1:0] c_ST_REPORT = 2'd3;

    logic [1:0]          r_state;
    logic                r_score_q;
    logic [COORD_W-1:0]  r_sx, r_sy;
    logic                r_big, r_wrong_n;
    logic signed [2:0]   r_dx, r_dy;
    logic                r_core_hit, r_ring_hit;
    logic [SHIP_W-1:0]   r_max_id;
    logic [3:0]          r_new_cnt;
    logic [SHIP_W-1:0]   r_map [c_CELLS];
    logic [c_CELLS-1:0]  r_struck;

    logic                      w_req, w_map_ok, w_shot_ok;
    logic [c_IDX_W-1:0]        w_map_idx, w_cell_idx;
    logic signed [2:0]         w_rad;
    logic signed [COORD_W+1:0] w_cx, w_cy;
    logic                      w_cell_in, w_corner, w_core, w_last, w_visit;
    logic [SHIP_W-1:0]         w_cell_id;
    logic [HIT_W:0]            w_sum;
    logic [NUM_SHIPS-1:0]      w_onehot;

    assign w_req     = bus.score && !r_score_q && (r_state == c_ST_IDLE);
    assign w_map_ok  = (bus.map_x >= c_LO_U) && (bus.map_x <= c_HI_U) &&
                       (bus.map_y >= c_LO_U) && (bus.map_y <= c_HI_U);
    assign w_map_idx = c_IDX_W'((int'(bus.map_x) - 1) * GRID + (int'(bus.map_y) - 1));
    assign w_shot_ok = (r_sx >= c_LO_U) && (r_sx <= c_HI_U) &&
                       (r_sy >= c_LO_U) && (r_sy <= c_HI_U);
    assign w_rad     = r_big ? 3'sd2 : 3'sd1;

    // Offsets are sign-extended so cells left of / above column 1 fall below c_LO_S.
    assign w_cx = $signed({2'b00, r_sx}) + $signed({{(COORD_W-1){r_dx[2]}}, r_dx});
    assign w_cy = $signed({2'b00, r_sy}) + $signed({{(COORD_W-1){r_dy[2]}}, r_dy});
    assign w_cell_in  = (w_cx >= c_LO_S) && (w_cx <= c_HI_S) &&
                        (w_cy >= c_LO_S) && (w_cy <= c_HI_S);
    assign w_cell_idx = w_cell_in ?
                        c_IDX_W'((int'(w_cx) - 1) * GRID + (int'(w_cy) - 1)) : '0;
    assign w_cell_id  = r_map[w_cell_idx];
    assign w_corner   = ((r_dx == w_rad) || (r_dx == -w_rad)) &&
                        ((r_dy == w_rad) || (r_dy == -w_rad));
    assign w_core     = r_big ? ((r_dx >= -3'sd1) && (r_dx <= 3'sd1) &&
                                 (r_dy >= -3'sd1) && (r_dy <= 3'sd1))
                              : ((r_dx == 3'sd0) && (r_dy == 3'sd0));
    assign w_visit    = w_cell_in && !w_corner;
    assign w_last     = (r_dx == w_rad) && (r_dy == w_rad);
    assign w_sum      = {1'b0, bus.num_hits} + (HIT_W+1)'(r_new_cnt);

    always_comb begin
        w_onehot = '0;
        for (int i = 1; i <= NUM_SHIPS; i++) begin
            if (r_max_id == SHIP_W'(i)) w_onehot[i-1] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= c_ST_IDLE;
            r_score_q        <= 1'b0;
            r_sx             <= '0;
            r_sy             <= '0;
            r_big            <= 1'b0;
            r_wrong_n        <= 1'b0;
            r_dx             <= '0;
            r_dy             <= '0;
            r_core_hit       <= 1'b0;
            r_ring_hit       <= 1'b0;
            r_max_id         <= '0;
            r_new_cnt        <= '0;
            r_struck         <= '0;
            for (int i = 0; i < c_CELLS; i++) r_map[i] <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.is_hit       <= 1'b0;
            bus.is_near_miss <= 1'b0;
            bus.is_miss      <= 1'b0;
            bus.biggest_ship <= '0;
            bus.num_hits     <= '0;
            bus.big_left     <= BL_W'(BIG_BOMBS);
            bus.wrong        <= 1'b0;
        end else begin
            r_score_q <= bus.score;
            bus.done  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.map_we && w_map_ok) begin
                        r_map[w_map_idx]    <= bus.map_ship;
                        r_struck[w_map_idx] <= 1'b0;
                    end
                    if (w_req) begin
                        r_sx     <= bus.shot_x;
                        r_sy     <= bus.shot_y;
                        r_big    <= bus.big;
                        bus.busy <= 1'b1;
                        r_state  <= c_ST_CHECK;
                    end
                end
                c_ST_CHECK: begin
                    if (!w_shot_ok || (r_big && (bus.big_left == '0))) begin
                        r_wrong_n <= 1'b1;
                        r_state   <= c_ST_REPORT;
                    end else begin
                        r_wrong_n  <= 1'b0;
                        r_dx       <= -w_rad;
                        r_dy       <= -w_rad;
                        r_core_hit <= 1'b0;
                        r_ring_hit <= 1'b0;
                        r_max_id   <= '0;
                        r_new_cnt  <= '0;
                        if (r_big) bus.big_left <= bus.big_left - 1'b1;
                        r_state    <= c_ST_SCAN;
                    end
                end
                c_ST_SCAN: begin
                    if (w_visit && (w_cell_id != '0)) begin
                        if (w_core) begin
                            r_core_hit <= 1'b1;
                            if (w_cell_id > r_max_id) r_max_id <= w_cell_id;
                            if (!r_struck[w_cell_idx]) begin
                                r_struck[w_cell_idx] <= 1'b1;
                                r_new_cnt            <= r_new_cnt + 4'd1;
                            end
                        end else begin
                            r_ring_hit <= 1'b1;
                        end
                    end
                    if (r_dx == w_rad) begin
                        r_dx <= -w_rad;
                        r_dy <= r_dy + 3'sd1;
                    end else begin
                        r_dx <= r_dx + 3'sd1;
                    end
                    if (w_last) r_state <= c_ST_REPORT;
                end
                c_ST_REPORT: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    r_state  <= c_ST_IDLE;
                    if (r_wrong_n) begin
                        bus.wrong        <= 1'b1;
                        bus.is_hit       <= 1'b0;
                        bus.is_near_miss <= 1'b0;
                        bus.is_miss      <= 1'b0;
                        bus.biggest_ship <= '0;
                    end else begin
                        bus.wrong        <= 1'b0;
                        bus.is_hit       <= r_core_hit;
                        bus.is_near_miss <= !r_core_hit && r_ring_hit;
                        bus.is_miss      <= !r_core_hit && !r_ring_hit;
                        bus.biggest_ship <= w_onehot;
                        bus.num_hits     <= w_sum[HIT_W] ? '1 : w_sum[HIT_W-1:0];
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_battleship_shot_engine.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_battleship_shot_engine : directed self-checking bench for the scorer    |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module tb_battleship_shot_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    battleship_shot_engine_if bus ();
    battleship_shot_engine dut (.clock(clk), .reset(rst), .bus(bus.slave));

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int pulses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic hit, input logic near,
                             input logic miss, input logic [4:0] bs, input int nh,
                             input int bl, input logic wr);
        check({tag, ".is_hit"},       32'(bus.is_hit),       32'(hit));
        check({tag, ".is_near_miss"}, 32'(bus.is_near_miss), 32'(near));
        check({tag, ".is_miss"},      32'(bus.is_miss),      32'(miss));
        check({tag, ".biggest_ship"}, 32'(bus.biggest_ship), 32'(bs));
        check({tag, ".num_hits"},     32'(bus.num_hits),     32'(nh));
        check({tag, ".big_left"},     32'(bus.big_left),     32'(bl));
        check({tag, ".wrong"},        32'(bus.wrong),        32'(wr));
    endtask

    task automatic write_cell(input int x, input int y, input int id);
        @(negedge clk);
        bus.map_we   = 1'b1;
        bus.map_x    = 4'(x);
        bus.map_y    = 4'(y);
        bus.map_ship = 3'(id);
        @(negedge clk);
        bus.map_we   = 1'b0;
    endtask

    // Latency is the number of posedges after the one that samples the edge.
    task automatic shoot(input int x, input int y, input logic b, output int l);
        @(negedge clk);
        bus.shot_x = 4'(x);
        bus.shot_y = 4'(y);
        bus.big    = b;
        bus.score  = 1'b1;
        l = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                l = k;
                break;
            end
        end
        bus.score = 1'b0;
    endtask

    initial begin
        bus.map_we = 1'b0; bus.map_x = '0; bus.map_y = '0; bus.map_ship = '0;
        bus.score  = 1'b0; bus.shot_x = '0; bus.shot_y = '0; bus.big = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check_res("rst", 0, 0, 0, 5'b00000, 0, 3, 0);

        write_cell(7, 6, 1);
        write_cell(8, 6, 1);
        shoot(7, 6, 1'b0, lat);
        check("small.lat", 32'(lat), 32'd11);
        check_res("small", 1, 0, 0, 5'b00001, 1, 3, 0);
        @(negedge clk);
        check("small.pulse", 32'(bus.done), 32'd0);
        check("small.busy", 32'(bus.busy), 32'd0);

        shoot(7, 6, 1'b0, lat);
        check_res("repeat", 1, 0, 0, 5'b00001, 1, 3, 0);
        shoot(6, 6, 1'b0, lat);
        check_res("near", 0, 1, 0, 5'b00000, 1, 3, 0);
        shoot(6, 7, 1'b0, lat);
        check_res("diag", 0, 0, 1, 5'b00000, 1, 3, 0);

        for (int x = 2; x <= 6; x++) write_cell(x, 3, 5);
        for (int x = 1; x <= 4; x++) write_cell(x, 2, 4);
        // Core x=2..4, y=2..4 covers three id4 cells (y=2) and three id5 cells (y=3).
        shoot(3, 3, 1'b1, lat);
        check("big.lat", 32'(lat), 32'd27);
        check_res("big", 1, 0, 0, 5'b10000, 7, 2, 0);

        // Core of (1,1) in-grid: (1,1),(2,1),(1,2) new id4,(2,2) already struck.
        shoot(1, 1, 1'b1, lat);
        check("corner_a.lat", 32'(lat), 32'd27);
        check_res("corner_a", 1, 0, 0, 5'b01000, 8, 1, 0);

        shoot(8, 8, 1'b1, lat);
        check_res("big3", 0, 1, 0, 5'b00000, 8, 0, 0);
        shoot(5, 5, 1'b1, lat);
        check("big4.lat", 32'(lat), 32'd2);
        check_res("big4", 0, 0, 0, 5'b00000, 8, 0, 1);
        shoot(0, 5, 1'b0, lat);
        check("x0.lat", 32'(lat), 32'd2);
        check_res("x0", 0, 0, 0, 5'b00000, 8, 0, 1);
        shoot(11, 5, 1'b0, lat);
        check_res("x11", 0, 0, 0, 5'b00000, 8, 0, 1);

        // Reset during the fifth scan cycle, with an extra score edge while busy.
        @(negedge clk);
        bus.shot_x = 4'd7; bus.shot_y = 4'd6; bus.big = 1'b0; bus.score = 1'b1;
        pulses = 0;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
            if (k == 0) bus.score = 1'b0;
            if (k == 1) bus.score = 1'b1;
            if (k == 5) begin
                check("midrst.busy_before", 32'(bus.busy), 32'd1);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        bus.score = 1'b0;
        check("midrst.no_done", 32'(pulses), 32'd0);
        check("midrst.busy", 32'(bus.busy), 32'd0);
        check("midrst.done", 32'(bus.done), 32'd0);
        check_res("midrst", 0, 0, 0, 5'b00000, 0, 3, 0);

        shoot(7, 6, 1'b0, lat);
        check("cleared.lat", 32'(lat), 32'd11);
        check_res("cleared", 0, 0, 1, 5'b00000, 0, 3, 0);

        // Map write and shot request in the same cycle; a second edge while busy is dropped.
        @(negedge clk);
        bus.map_we = 1'b1; bus.map_x = 4'd5; bus.map_y = 4'd5; bus.map_ship = 3'd3;
        bus.shot_x = 4'd5; bus.shot_y = 4'd5; bus.big = 1'b0; bus.score = 1'b1;
        pulses = 0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.map_we = 1'b0;
            if (bus.done === 1'b1) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (k == 2) bus.score = 1'b0;
            if (k == 3) bus.score = 1'b1;
        end
        bus.score = 1'b0;
        check("wrreq.pulses", 32'(pulses), 32'd1);
        check("wrreq.lat", 32'(lat), 32'd11);
        check_res("wrreq", 1, 0, 0, 5'b00100, 1, 3, 0);

        write_cell(4, 1, 2);
        write_cell(10, 10, 2);
        write_cell(1, 4, 3);
        shoot(1, 1, 1'b1, lat);
        check("corner_b.lat", 32'(lat), 32'd27);
        check_res("corner_b", 0, 0, 1, 5'b00000, 1, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
